pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_pkg.sv | 24 ++
 rtl/ras_stack.sv | 59 +++++
 rtl/pc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pc_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// ============================================================================
//  Module      : pc_ctrl_pkg
//  Description : Shared definitions for the program-counter controller:
//                controller state encoding and default sizing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_ctrl_pkg;

    // Default program-counter width and return-address-stack depth
    localparam int PC_W      = 8;
    localparam int RAS_DEPTH = 4;

    // Controller states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage : pc_ctrl_pkg

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
//  Module      : ras_stack
//  Description : Return-address LIFO. A push while full and a pop while empty
//                are dropped; the caller is expected to flag those itself.
//  Ports       : clk, reset (sync, active low), push, pop, din[D-1:0],
//                top[D-1:0] (most recent entry), full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int D         = pc_ctrl_pkg::PC_W,
    parameter int RAS_DEPTH = pc_ctrl_pkg::RAS_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);

    // Stack pointer counts occupied entries (0..RAS_DEPTH)
    localparam int SPW = $clog2(RAS_DEPTH + 1);
    localparam int AW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [D-1:0]   mem [RAS_DEPTH];
    logic [SPW-1:0] sp;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;

    assign full   = (sp == SPW'(RAS_DEPTH));
    assign empty  = (sp == '0);
    assign wr_idx = AW'(sp);
    assign rd_idx = AW'(sp - SPW'(1));
    assign top    = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    // Storage needs no reset: entries above the pointer are never read
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule : ras_stack

`default_nettype wire

// File: rtl/pc_ctrl.sv
// ============================================================================
//  Module      : pc_ctrl
//  Description : Program-counter control: branch / call / return / halt
//                sequencing with a one-cycle fetch flush after every jump.
//                Define PC_CTRL_RAS_EN to build the return-address stack;
//                without it calls act as plain taken branches, returns are
//                ignored and the stack flags are tied low.
//  Ports       : clk, reset (sync, active low), prog_ctr, br_req, br_taken,
//                br_tgt, call_req, ret_req, halt_req, resume  (inputs)
//                jump_en, target, flush, halted, ras_ovf, ras_unf (outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ctrl #(
    parameter int D         = pc_ctrl_pkg::PC_W,
    parameter int RAS_DEPTH = pc_ctrl_pkg::RAS_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] prog_ctr,
    input  logic         br_req,
    input  logic         br_taken,
    input  logic [D-1:0] br_tgt,
    input  logic         call_req,
    input  logic         ret_req,
    input  logic         halt_req,
    input  logic         resume,
    output logic         jump_en,
    output logic [D-1:0] target,
    output logic         flush,
    output logic         halted,
    output logic         ras_ovf,
    output logic         ras_unf
);
    import pc_ctrl_pkg::*;

    state_t state;
    state_t next_state;

`ifdef PC_CTRL_RAS_EN
    logic         stk_push;
    logic         stk_pop;
    logic         set_ovf;
    logic         set_unf;
    logic [D-1:0] stk_top;
    logic         stk_full;
    logic         stk_empty;
    logic [D-1:0] ret_addr;

    // Return address wraps modulo 2^D
    assign ret_addr = prog_ctr + D'(1);

    ras_stack #(
        .D         (D),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (ret_addr),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );
`endif

    always_comb begin
        next_state = state;
        jump_en    = 1'b0;
        target     = '0;
        flush      = 1'b0;
        halted     = 1'b0;
`ifdef PC_CTRL_RAS_EN
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
`endif
        // Outputs are forced quiet while reset is held
        if (reset) begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        // Reload the current PC so it holds
                        jump_en    = 1'b1;
                        target     = prog_ctr;
                        next_state = HALT;
                    end else if (ret_req) begin
`ifdef PC_CTRL_RAS_EN
                        if (!stk_empty) begin
                            jump_en    = 1'b1;
                            target     = stk_top;
                            stk_pop    = 1'b1;
                            next_state = FLUSH;
                        end else begin
                            set_unf = 1'b1;
                        end
`endif
                    end else if (call_req) begin
                        jump_en    = 1'b1;
                        target     = br_tgt;
                        next_state = FLUSH;
`ifdef PC_CTRL_RAS_EN
                        // Jump still taken when full; only the push is lost
                        if (stk_full) begin
                            set_ovf = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                        end
`endif
                    end else if (br_req && br_taken) begin
                        jump_en    = 1'b1;
                        target     = br_tgt;
                        next_state = FLUSH;
                    end
                end
                FLUSH: begin
                    flush      = 1'b1;
                    next_state = RUN;
                end
                HALT: begin
                    halted = 1'b1;
                    if (resume) begin
                        // Let the PC step past the halt instruction
                        next_state = RUN;
                    end else begin
                        jump_en = 1'b1;
                        target  = prog_ctr;
                    end
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

`ifdef PC_CTRL_RAS_EN
    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            ras_ovf <= ras_ovf | set_ovf;
            ras_unf <= ras_unf | set_unf;
        end
    end
`else
    assign ras_ovf = 1'b0;
    assign ras_unf = 1'b0;
`endif

endmodule : pc_ctrl

`default_nettype wire

// File: tb/tb_pc_ctrl.sv
// ============================================================================
//  Module      : tb_pc_ctrl
//  Description : Self-checking bench for pc_ctrl. Each issued cycle pushes
//                the reference model's expected outputs into a queue that a
//                separate monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_ctrl;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] prog_ctr;
    logic         br_req;
    logic         br_taken;
    logic [W-1:0] br_tgt;
    logic         call_req;
    logic         ret_req;
    logic         halt_req;
    logic         resume;
    logic         jump_en;
    logic [W-1:0] target;
    logic         flush;
    logic         halted;
    logic         ras_ovf;
    logic         ras_unf;

    int total = 0;
    int bad   = 0;

    pc_ctrl #(
        .D         (W),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .prog_ctr (prog_ctr),
        .br_req   (br_req),
        .br_taken (br_taken),
        .br_tgt   (br_tgt),
        .call_req (call_req),
        .ret_req  (ret_req),
        .halt_req (halt_req),
        .resume   (resume),
        .jump_en  (jump_en),
        .target   (target),
        .flush    (flush),
        .halted   (halted),
        .ras_ovf  (ras_ovf),
        .ras_unf  (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PC_CTRL_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    // ---------------- reference model ----------------
    // mode: 0 = running, 1 = squashing the fetch after a jump, 2 = halted
    int           m_mode = 0;
    logic [W-1:0] m_stk[$];
    bit           m_ovf = 0;
    bit           m_unf = 0;

    // Expected outputs: {jump_en, target, flush, halted, ras_ovf, ras_unf}
    logic [12:0]  exp_q[$];
    string        name_q[$];

    task automatic issue(input string nm);
        logic         e_j  = 1'b0;
        logic [W-1:0] e_t  = '0;
        logic         e_f  = 1'b0;
        logic         e_h  = 1'b0;
        logic         e_o  = m_ovf;
        logic         e_u  = m_unf;
        logic [W-1:0] ra;
        if (!reset) begin
            m_mode = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (m_mode == 0) begin
            if (halt_req) begin
                e_j = 1'b1; e_t = prog_ctr; m_mode = 2;
            end else if (ret_req) begin
                if (RAS_ON) begin
                    if (m_stk.size() > 0) begin
                        e_j = 1'b1; e_t = m_stk.pop_back(); m_mode = 1;
                    end else begin
                        m_unf = 1;
                    end
                end
            end else if (call_req) begin
                e_j = 1'b1; e_t = br_tgt; m_mode = 1;
                if (RAS_ON) begin
                    ra = prog_ctr + 8'd1;
                    if (m_stk.size() == DEPTH) m_ovf = 1;
                    else m_stk.push_back(ra);
                end
            end else if (br_req && br_taken) begin
                e_j = 1'b1; e_t = br_tgt; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            e_f = 1'b1; m_mode = 0;
        end else begin
            e_h = 1'b1;
            if (resume) m_mode = 0;
            else begin e_j = 1'b1; e_t = prog_ctr; end
        end
        exp_q.push_back({e_j, e_t, e_f, e_h, e_o, e_u});
        name_q.push_back(nm);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            logic [12:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {jump_en, target, flush, halted, ras_ovf, ras_unf};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s t=%0t got j=%b t=%h f=%b h=%b o=%b u=%b want j=%b t=%h f=%b h=%b o=%b u=%b",
                         nm, $time, a[12], a[11:4], a[3], a[2], a[1], a[0],
                         e[12], e[11:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input string nm, input logic r, input logic [W-1:0] pc,
                       input logic br, input logic bt, input logic [W-1:0] tg,
                       input logic cl, input logic rt, input logic hl, input logic rs);
        @(posedge clk);
        #1;
        reset = r; prog_ctr = pc; br_req = br; br_taken = bt; br_tgt = tg;
        call_req = cl; ret_req = rt; halt_req = hl; resume = rs;
        issue(nm);
        #1;
    endtask

    task automatic idle(input string nm, input logic [W-1:0] pc);
        cyc(nm, 1'b1, pc, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, req);
        end
    endtask

    initial begin
        reset = 1'b0; prog_ctr = '0; br_req = 1'b0; br_taken = 1'b0; br_tgt = '0;
        call_req = 1'b0; ret_req = 1'b0; halt_req = 1'b0; resume = 1'b0;

        // Reset blocks every request
        cyc("rst0", 1'b0, 8'h12, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_jump", jump_en, 0);
        chk("rst_target", target, 0);
        cyc("rst1", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Taken branch then flush
        cyc("br", 1'b1, 8'h10, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_jump", jump_en, 1);
        chk("br_target", target, 32'h40);
        idle("br_flush", 8'h40);
        chk("br_flush", flush, 1);
        chk("br_flush_jump", jump_en, 0);

        // Not-taken branch
        cyc("nt", 1'b1, 8'h41, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nt_jump", jump_en, 0);
        idle("nt_next", 8'h42);
        chk("nt_noflush", flush, 0);

        // Call / return, including 0xFF wrap
        cyc("call20", 1'b1, 8'h20, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("call_target", target, 32'h80);
        idle("call_fl", 8'h80);
        cyc("ret21", 1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        if (RAS_ON) chk("ret_target", target, 32'h21);
        else chk("ret_ignored", jump_en, 0);
        idle("ret_fl", 8'h21);
        cyc("callff", 1'b1, 8'hFF, 1'b0, 1'b0, 8'h90, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("callff_fl", 8'h90);
        cyc("ret00", 1'b1, 8'h90, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        if (RAS_ON) chk("ret_wrap", target, 32'h00);
        idle("ret00_fl", 8'h00);

        // Five calls into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            cyc("call_n", 1'b1, 8'(i), 1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b0);
            idle("call_n_fl", 8'hA0);
        end
        chk("ovf", ras_ovf, 32'(RAS_ON));
        cyc("ret_first", 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        if (RAS_ON) chk("ret_after_ovf", target, 32'h05);
        idle("ret_first_fl", 8'h05);
        for (int i = 0; i < 3; i++) begin
            cyc("ret_drain", 1'b1, 8'hB0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            idle("ret_drain_fl", 8'hB1);
        end
        cyc("ret_empty", 1'b1, 8'hC0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ret_empty_jump", jump_en, 0);
        idle("after_unf", 8'hC1);
        chk("unf", ras_unf, 32'(RAS_ON));

        // Halt wins over ret, holds PC, resume releases
        cyc("halt", 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("halt_target", target, 32'h33);
        chk("halt_jump", jump_en, 1);
        for (int i = 0; i < 10; i++) begin
            cyc("halt_hold", 1'b1, 8'h33, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("halted", halted, 1);
        chk("halt_hold_target", target, 32'h33);
        cyc("resume", 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("resume_jump", jump_en, 0);
        idle("post_resume", 8'h34);
        chk("post_resume_halted", halted, 0);

        // Reset in HALT with two stack entries
        cyc("rst2", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc("c2", 1'b1, 8'h50, 1'b0, 1'b0, 8'h60, 1'b1, 1'b0, 1'b0, 1'b0);
            idle("c2_fl", 8'h60);
        end
        cyc("h2", 1'b1, 8'h61, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("h2_hold", 8'h61);
        cyc("rst_halt", 1'b0, 8'h61, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_halt_halted", halted, 0);
        cyc("ret_post_rst", 1'b1, 8'h62, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ret_post_rst_jump", jump_en, 0);
        idle("after_rst_ret", 8'h63);
        chk("unf_post_rst", ras_unf, 32'(RAS_ON));

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] pc;
            pc = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            cyc("rand", ($urandom_range(0, 40) != 0), pc,
                ($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_ctrl

`default_nettype wire
